host_mailbox_ctrl: RTL and testbench
====================================

Name: host_mailbox_ctrl

Overview:
- Host-side counterpart of the CPU's external memory port.
- Holds the t1c_riscv_cpu in reset and preloads argument words into the mailbox window of data memory through Ext_MemWrite/Ext_WriteData/Ext_DataAdr, then releases the CPU.
- Snoops the CPU's MemWrite/DataAdr/WriteData stores into the same window, captures results and detects the done flag, with a timeout.
- Replaces the hand-sequenced load/check flow with synthesizable control for on-board runs.

Parameters:
- MBOX_BASE, 32'h02000000, byte address of mailbox word 0.
- IDX_W, 2, mailbox index width; the window holds NWORDS = 2**IDX_W words.
- SETTLE_CYC, 2, cycles reset stays asserted after the last preload write.
- TIMEOUT, 100000, maximum RUN cycles before abort.
- CNT_W, 17, timeout counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state on the rising edge
- reset  in  1  synchronous, active-high; returns the block to IDLE
- start  in  1  one-cycle pulse that begins a session; ignored in LOAD/SETTLE/RUN
- arg_data  in  NWORDS*32  preload values; word i is bits [32i+31:32i]
- arg_count  in  IDX_W+1  number of words to preload (0..NWORDS); larger values clamp to NWORDS
- done_idx  in  IDX_W  mailbox index of the CPU done flag
- rd_idx  in  IDX_W  selects the captured word driven on rd_word
- MemWrite  in  1  CPU store strobe
- DataAdr  in  32  CPU store address
- WriteData  in  32  CPU store data
- cpu_reset  out  1  reset to CPU
- Ext_MemWrite  out  1  preload write strobe
- Ext_WriteData  out  32  preload data
- Ext_DataAdr  out  32  preload address
- rd_word  out  32  captured word at rd_idx (combinational mux of registers)
- cap_valid  out  NWORDS  bit i set once the CPU stores to word i in this session
- busy  out  1  high in LOAD, SETTLE, RUN
- done  out  1  sticky; CPU wrote 1 to the done word
- timeout  out  1  sticky; RUN exceeded TIMEOUT cycles

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high.
- All outputs except rd_word are registered.
- Reset values:
  - cpu_reset=1
  - Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=0
  - cap_valid=0, capture registers=0
  - busy=0, done=0, timeout=0
  - state=IDLE
- Reset taken mid-session aborts immediately; cpu_reset returns to 1 on the same edge.
- IDLE: cpu_reset=1.
  - start -> clear cap_valid, done, timeout and capture registers.
  - Latch the clamped arg_count, done_idx and arg_data.
  - Go to LOAD if count>0, else SETTLE.
- LOAD: one word per cycle.
  - Ext_MemWrite=1, Ext_DataAdr=MBOX_BASE+4*i, Ext_WriteData=word i, for i=0..count-1.
  - The strobe is high for exactly count consecutive cycles.
  - After the last word -> SETTLE.
- SETTLE: Ext_* driven to 0, cpu_reset=1 for SETTLE_CYC cycles, then -> RUN with cpu_reset=0.
- RUN: Ext_* stay 0; timeout counter starts at 0 and increments each cycle.
  - A store is in-window when all hold:
    - MemWrite=1
    - DataAdr[1:0]=0
    - (DataAdr-MBOX_BASE)>>2 < NWORDS
    - DataAdr>=MBOX_BASE
  - In-window store to index k: capture[k]<=WriteData, cap_valid[k]<=1. A later store to the same k overwrites.
  - Out-of-window or misaligned stores are ignored.
  - Store to the latched done_idx with WriteData==32'd1: captured as above, then -> DONE with done=1 next cycle. Any other value to the done word is only captured.
  - Counter reaches TIMEOUT-1 with no done store -> TIMEOUT.
  - A done store in the same cycle as expiry resolves as DONE.
- DONE: cpu_reset=1, busy=0; captures and flags frozen until the next start.
- TIMEOUT: same as DONE but timeout=1.
- start in DONE or TIMEOUT begins a new session, behaving as from IDLE.
- Stores seen outside RUN are ignored.
- Address arithmetic is 32-bit unsigned modulo 2**32; no preload address wraps for legal MBOX_BASE.

Test Plan:
- Sum of naturals, CPU stub: arg_data={0,0,0,15}, arg_count=3, done_idx=2, start.
  - Required: Ext writes 15@02000000, 0@02000004, 0@02000008 on 3 consecutive cycles, then cpu_reset low after 2 cycles.
  - Stub stores 120@02000004 then 1@02000008 -> done=1, rd_word(idx1)=120, cap_valid=4'b0110.
- AP preload: arg_count=4, arg_data {0,15,6,5}, done_idx=3.
  - Required: 4 writes at 0x..00/04/08/0C with 5,6,15,0.
  - Stub stores 89@0x0200000C -> captured, no done; then 1@0x0200000C -> done=1.
- Filtering:
  - Stub stores 7@0x01FFFFFC, 9@0x02000010, 3@0x02000002 -> cap_valid stays 0.
  - Store of 2 to the done word -> captured, done=0.
- Timeout with TIMEOUT=50 and a silent stub:
  - Required: timeout=1 exactly 50 cycles after cpu_reset falls, cpu_reset=1, busy=0.
  - Variant: done store on cycle 50 -> done=1, timeout=0.
- Control edges:
  - start during RUN is ignored.
  - arg_count=7 clamps to 4 writes.
  - arg_count=0 goes straight to SETTLE.
  - reset mid-LOAD -> Ext_MemWrite=0, cpu_reset=1, state IDLE next cycle.
  - A new start after DONE clears done and cap_valid.

Source files
------------

// File: rtl/host_mailbox_ctrl.sv
// Host-side mailbox controller: holds the CPU in reset, preloads argument words through
// the external memory port, releases the CPU, then snoops its stores for results and a done flag.
module host_mailbox_ctrl #(
    parameter logic [31:0] MBOX_BASE  = 32'h0200_0000,
    parameter int          IDX_W      = 2,
    parameter int          SETTLE_CYC = 2,
    parameter int          TIMEOUT    = 100000,
    parameter int          CNT_W      = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [(2**IDX_W)*32-1:0] arg_data,
    input  logic [IDX_W:0]           arg_count,
    input  logic [IDX_W-1:0]         done_idx,
    input  logic [IDX_W-1:0]         rd_idx,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    output logic                     cpu_reset,
    output logic                     Ext_MemWrite,
    output logic [31:0]              Ext_WriteData,
    output logic [31:0]              Ext_DataAdr,
    output logic [31:0]              rd_word,
    output logic [(2**IDX_W)-1:0]    cap_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout
);
    localparam int NWORDS = 2**IDX_W;
    localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE, S_TIMEOUT
    } stateT;

    stateT                    state, nextState;
    logic [IDX_W:0]           countReg;
    logic [IDX_W-1:0]         doneIdxReg;
    logic [(NWORDS-1)*32-1:0] argRest;
    logic [IDX_W-1:0]         loadIdx;
    logic [SET_W-1:0]         settleCnt;
    logic [CNT_W-1:0]         runCnt;
    logic [31:0]              capReg [NWORDS];

    logic [IDX_W:0]   clampCount;
    logic             canStart, lastWord, settleLast, expiry;
    logic [IDX_W-1:0] nextIdx, winIdx;
    logic [31:0]      storeOfs;
    logic             inWindow, doneStore;

    assign clampCount = (arg_count > (IDX_W+1)'(NWORDS)) ? (IDX_W+1)'(NWORDS) : arg_count;
    assign canStart   = start && (state == S_IDLE || state == S_DONE || state == S_TIMEOUT);
    assign nextIdx    = loadIdx + IDX_W'(1);
    assign lastWord   = (({1'b0, loadIdx} + (IDX_W+1)'(1)) == countReg);
    assign settleLast = (settleCnt == SET_W'(SETTLE_CYC - 1));
    assign expiry     = (runCnt == CNT_W'(TIMEOUT - 1));

    // Window test is done on the wrapped offset plus an explicit lower-bound compare.
    assign storeOfs  = DataAdr - MBOX_BASE;
    assign inWindow  = MemWrite && (DataAdr[1:0] == 2'b00) && (DataAdr >= MBOX_BASE)
                       && ((storeOfs >> 2) < 32'(NWORDS));
    assign winIdx    = storeOfs[IDX_W+1:2];
    assign doneStore = (state == S_RUN) && inWindow && (winIdx == doneIdxReg)
                       && (WriteData == 32'd1);

    assign rd_word = capReg[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nextState;
    end

    // NOTE: nextState gets its default before the case so no path leaves it unassigned,
    // which keeps this block purely combinational instead of inferring a latch.
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE, S_DONE, S_TIMEOUT:
                if (canStart) nextState = (clampCount != '0) ? S_LOAD : S_SETTLE;
            S_LOAD:   if (lastWord)   nextState = S_SETTLE;
            S_SETTLE: if (settleLast) nextState = S_RUN;
            S_RUN: begin
                if (doneStore)   nextState = S_DONE;
                else if (expiry) nextState = S_TIMEOUT;
            end
            default: nextState = S_IDLE;
        endcase
    end

    // NOTE: the capture array is a handful of flops, not RAM, so it is cleared by reset
    // and by every start; rd_word must never show stale data from an earlier session.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            cap_valid     <= '0;
            Ext_MemWrite  <= 1'b0;
            Ext_WriteData <= '0;
            Ext_DataAdr   <= '0;
            countReg      <= '0;
            doneIdxReg    <= '0;
            argRest       <= '0;
            loadIdx       <= '0;
            settleCnt     <= '0;
            runCnt        <= '0;
            for (int i = 0; i < NWORDS; i++) capReg[i] <= '0;
        end else begin
            cpu_reset <= (nextState != S_RUN);
            busy      <= (nextState inside {S_LOAD, S_SETTLE, S_RUN});
            // NOTE: non-blocking defaults here are overridden by later assignments in the
            // same block; the last scheduled update wins, so ordering below is deliberate.
            Ext_MemWrite  <= 1'b0;
            Ext_WriteData <= '0;
            Ext_DataAdr   <= '0;
            settleCnt     <= (state == S_SETTLE) ? settleCnt + SET_W'(1) : '0;
            runCnt        <= (state == S_RUN) ? runCnt + CNT_W'(1) : '0;

            if (canStart) begin
                cap_valid  <= '0;
                done       <= 1'b0;
                timeout    <= 1'b0;
                for (int i = 0; i < NWORDS; i++) capReg[i] <= '0;
                countReg   <= clampCount;
                doneIdxReg <= done_idx;
                argRest    <= arg_data[NWORDS*32-1:32];
                loadIdx    <= '0;
                if (clampCount != '0) begin
                    Ext_MemWrite  <= 1'b1;
                    Ext_DataAdr   <= MBOX_BASE;
                    Ext_WriteData <= arg_data[31:0];
                end
            end

            // Word 0 goes out on the start edge, so argRest holds words 1..NWORDS-1.
            if (state == S_LOAD && !lastWord) begin
                loadIdx       <= nextIdx;
                Ext_MemWrite  <= 1'b1;
                Ext_DataAdr   <= MBOX_BASE + (32'(nextIdx) << 2);
                Ext_WriteData <= argRest[32*loadIdx +: 32];
            end

            if (state == S_RUN) begin
                if (inWindow) begin
                    capReg[winIdx]    <= WriteData;
                    cap_valid[winIdx] <= 1'b1;
                end
                if (doneStore)   done    <= 1'b1;
                else if (expiry) timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_host_mailbox_ctrl.sv
// Self-checking bench for host_mailbox_ctrl: directed sequences, a store-vector table and
// randomized sessions compared against a session-level reference model.
module tb_host_mailbox_ctrl;
    localparam int          IDX_W      = 2;
    localparam int          NWORDS     = 4;
    localparam int          SETTLE_CYC = 2;
    localparam int          TIMEOUT    = 50;
    localparam int          CNT_W      = 8;
    localparam logic [31:0] BASE       = 32'h0200_0000;

    logic                 clk = 1'b0;
    logic                 reset, start;
    logic [NWORDS*32-1:0] arg_data;
    logic [IDX_W:0]       arg_count;
    logic [IDX_W-1:0]     done_idx, rd_idx;
    logic                 MemWrite;
    logic [31:0]          DataAdr, WriteData;
    logic                 cpu_reset, Ext_MemWrite;
    logic [31:0]          Ext_WriteData, Ext_DataAdr, rd_word;
    logic [NWORDS-1:0]    cap_valid;
    logic                 busy, done, timeout;

    host_mailbox_ctrl #(
        .MBOX_BASE(BASE), .IDX_W(IDX_W), .SETTLE_CYC(SETTLE_CYC),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .arg_data(arg_data),
        .arg_count(arg_count), .done_idx(done_idx), .rd_idx(rd_idx),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .cpu_reset(cpu_reset), .Ext_MemWrite(Ext_MemWrite),
        .Ext_WriteData(Ext_WriteData), .Ext_DataAdr(Ext_DataAdr),
        .rd_word(rd_word), .cap_valid(cap_valid), .busy(busy),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [31:0]       adr;
        logic [31:0]       data;
        logic [NWORDS-1:0] expValid;
        logic              expDone;
        logic [IDX_W-1:0]  rdIdx;
        logic [31:0]       rdExp;
    } storeVecT;

    storeVecT vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        start     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
    endtask

    task automatic startSession(input logic [NWORDS*32-1:0] data, input logic [IDX_W:0] cnt,
                                input logic [IDX_W-1:0] didx);
        arg_data  = data;
        arg_count = cnt;
        done_idx  = didx;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        // Scramble the argument inputs so a design that fails to latch them is exposed.
        arg_data  = {$urandom, $urandom, $urandom, $urandom};
        arg_count = 3'(~cnt);
        done_idx  = ~didx;
    endtask

    // Called right after the start edge; returns in RUN cycle 0.
    task automatic checkLoad(input logic [NWORDS*32-1:0] data, input int cnt, input string tag);
        int n;
        n = (cnt > NWORDS) ? NWORDS : cnt;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s load%0d strobe", tag, i), 32'(Ext_MemWrite), 32'd1);
            check($sformatf("%s load%0d addr", tag, i), Ext_DataAdr, BASE + 32'(4 * i));
            check($sformatf("%s load%0d data", tag, i), Ext_WriteData, data[32*i +: 32]);
            check($sformatf("%s load%0d cpu_reset", tag, i), 32'(cpu_reset), 32'd1);
            tick();
        end
        for (int s = 0; s < SETTLE_CYC; s++) begin
            check($sformatf("%s settle%0d strobe", tag, s), 32'(Ext_MemWrite), 32'd0);
            check($sformatf("%s settle%0d addr", tag, s), Ext_DataAdr, 32'd0);
            check($sformatf("%s settle%0d cpu_reset", tag, s), 32'(cpu_reset), 32'd1);
            check($sformatf("%s settle%0d busy", tag, s), 32'(busy), 32'd1);
            tick();
        end
        check({tag, " run cpu_reset"}, 32'(cpu_reset), 32'd0);
        check({tag, " run strobe"}, 32'(Ext_MemWrite), 32'd0);
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        tick();
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
    endtask

    task automatic checkCap(input int idx, input logic [31:0] exp, input string name);
        rd_idx = idx[IDX_W-1:0];
        #1;
        check(name, rd_word, exp);
    endtask

    task automatic pickStore(output logic [31:0] adr, output logic [31:0] data);
        case ($urandom_range(0, 5))
            0, 1, 2: adr = BASE + 32'(4 * $urandom_range(0, NWORDS - 1));
            3:       adr = BASE + 32'(4 * $urandom_range(0, NWORDS - 1)) + 32'($urandom_range(1, 3));
            4:       adr = BASE - 32'(4 * $urandom_range(1, 4));
            default: adr = BASE + 32'(4 * NWORDS) + 32'(4 * $urandom_range(0, 100));
        endcase
        data = ($urandom_range(0, 9) == 0) ? 32'd1 : 32'($urandom);
    endtask

    // Reference model: the window and done rules applied directly to each store, one per RUN cycle.
    task automatic randomSession(input int s);
        logic [NWORDS*32-1:0] data;
        int                   cnt, didx, k;
        logic [31:0]          mCap [NWORDS];
        logic [NWORDS-1:0]    mValid;
        bit                   mDone, mTimeout, doStore;
        logic [31:0]          adr, wdata, ofs;
        string                tag;

        tag = $sformatf("rnd%0d", s);
        for (int i = 0; i < NWORDS; i++) data[32*i +: 32] = $urandom;
        cnt  = $urandom_range(0, 7);
        didx = $urandom_range(0, NWORDS - 1);
        startSession(data, cnt[IDX_W:0], didx[IDX_W-1:0]);
        check({tag, " cleared valid"}, 32'(cap_valid), 32'd0);
        check({tag, " cleared done"}, 32'(done | timeout), 32'd0);
        checkLoad(data, cnt, tag);

        for (int i = 0; i < NWORDS; i++) mCap[i] = '0;
        mValid   = '0;
        mDone    = 1'b0;
        mTimeout = 1'b0;
        for (int c = 0; c < TIMEOUT && !mDone && !mTimeout; c++) begin
            doStore = ($urandom_range(0, 2) != 0);
            pickStore(adr, wdata);
            MemWrite  = doStore;
            DataAdr   = adr;
            WriteData = wdata;
            start     = ($urandom_range(0, 15) == 0);
            ofs = adr - BASE;
            if (doStore && adr >= BASE && adr % 4 == 0 && ofs / 4 < NWORDS) begin
                k = int'(ofs / 4);
                mCap[k]   = wdata;
                mValid[k] = 1'b1;
                if (k == didx && wdata == 32'd1) mDone = 1'b1;
            end
            if (!mDone && c == TIMEOUT - 1) mTimeout = 1'b1;
            tick();
        end
        idleInputs();

        check({tag, " done"}, 32'(done), 32'(mDone));
        check({tag, " timeout"}, 32'(timeout), 32'(mTimeout));
        check({tag, " cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " cap_valid"}, 32'(cap_valid), 32'(mValid));
        for (int i = 0; i < NWORDS; i++) checkCap(i, mCap[i], $sformatf("%s cap%0d", tag, i));

        // Stores after the session ends must leave everything frozen.
        store(BASE, 32'hDEAD_0000 + 32'(s));
        store(BASE + 32'(4 * (NWORDS - 1)), 32'd1);
        check({tag, " frozen valid"}, 32'(cap_valid), 32'(mValid));
        checkCap(0, mCap[0], {tag, " frozen cap0"});
        check({tag, " frozen flags"}, 32'({done, timeout}), 32'({mDone, mTimeout}));
    endtask

    initial begin
        vecs[0] = '{32'h01FF_FFFC, 32'd7,  4'b0000, 1'b0, 2'd0, 32'd0};
        vecs[1] = '{32'h0200_0010, 32'd9,  4'b0000, 1'b0, 2'd0, 32'd0};
        vecs[2] = '{32'h0200_0002, 32'd3,  4'b0000, 1'b0, 2'd0, 32'd0};
        vecs[3] = '{32'h0200_000C, 32'd89, 4'b1000, 1'b0, 2'd3, 32'd89};
        vecs[4] = '{32'h0200_000C, 32'd2,  4'b1000, 1'b0, 2'd3, 32'd2};
        vecs[5] = '{32'h0200_0000, 32'd44, 4'b1001, 1'b0, 2'd0, 32'd44};
        vecs[6] = '{32'h0200_0008, 32'd1,  4'b1101, 1'b0, 2'd2, 32'd1};
        vecs[7] = '{32'h0200_000C, 32'd1,  4'b1101, 1'b1, 2'd3, 32'd1};
        vecs[8] = '{32'h0200_0004, 32'd77, 4'b1101, 1'b1, 2'd1, 32'd0};

        reset     = 1'b1;
        idleInputs();
        arg_data  = '0;
        arg_count = '0;
        done_idx  = '0;
        rd_idx    = '0;
        tick();
        tick();
        check("reset cpu_reset", 32'(cpu_reset), 32'd1);
        check("reset ext strobe", 32'(Ext_MemWrite), 32'd0);
        check("reset ext data", Ext_WriteData, 32'd0);
        check("reset ext addr", Ext_DataAdr, 32'd0);
        check("reset flags", 32'({busy, done, timeout}), 32'd0);
        check("reset cap_valid", 32'(cap_valid), 32'd0);
        check("reset rd_word", rd_word, 32'd0);
        reset = 1'b0;
        tick();
        check("idle busy", 32'(busy), 32'd0);

        // Sum of naturals with a CPU stub.
        startSession({32'd0, 32'd0, 32'd0, 32'd15}, 3'd3, 2'd2);
        checkLoad({32'd0, 32'd0, 32'd0, 32'd15}, 3, "sum");
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sum start in run strobe", 32'(Ext_MemWrite), 32'd0);
        check("sum start in run cpu_reset", 32'(cpu_reset), 32'd0);
        check("sum start in run busy", 32'(busy), 32'd1);
        store(BASE + 32'd4, 32'd120);
        check("sum done before flag", 32'(done), 32'd0);
        store(BASE + 32'd8, 32'd1);
        check("sum done", 32'(done), 32'd1);
        check("sum cpu_reset", 32'(cpu_reset), 32'd1);
        check("sum busy", 32'(busy), 32'd0);
        check("sum cap_valid", 32'(cap_valid), 32'h6);
        checkCap(1, 32'd120, "sum rd_word idx1");
        store(BASE, 32'd55);
        check("sum frozen cap_valid", 32'(cap_valid), 32'h6);

        // Preload of four words, then the store-vector table against done index 3.
        startSession({32'd0, 32'd15, 32'd6, 32'd5}, 3'd4, 2'd3);
        check("ap restart done", 32'(done), 32'd0);
        check("ap restart cap_valid", 32'(cap_valid), 32'd0);
        checkCap(1, 32'd0, "ap restart cap1");
        checkLoad({32'd0, 32'd15, 32'd6, 32'd5}, 4, "ap");
        for (int i = 0; i < 9; i++) begin
            store(vecs[i].adr, vecs[i].data);
            check($sformatf("tbl%0d cap_valid", i), 32'(cap_valid), 32'(vecs[i].expValid));
            check($sformatf("tbl%0d done", i), 32'(done), 32'(vecs[i].expDone));
            checkCap(int'(vecs[i].rdIdx), vecs[i].rdExp, $sformatf("tbl%0d rd_word", i));
        end

        // Count 7 clamps to four writes, then a silent stub runs into the timeout.
        startSession({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 3'd7, 2'd0);
        checkLoad({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 7, "clamp");
        for (int c = 1; c < TIMEOUT; c++) tick();
        check("to last run cycle timeout", 32'(timeout), 32'd0);
        check("to last run cycle busy", 32'(busy), 32'd1);
        tick();
        check("to timeout", 32'(timeout), 32'd1);
        check("to cpu_reset", 32'(cpu_reset), 32'd1);
        check("to busy", 32'(busy), 32'd0);
        check("to done", 32'(done), 32'd0);

        // Count 0 skips LOAD; a done store in the expiry cycle wins over the timeout.
        startSession({32'h1, 32'h2, 32'h3, 32'h4}, 3'd0, 2'd1);
        check("zero strobe", 32'(Ext_MemWrite), 32'd0);
        check("zero busy", 32'(busy), 32'd1);
        check("zero timeout cleared", 32'(timeout), 32'd0);
        checkLoad({32'h1, 32'h2, 32'h3, 32'h4}, 0, "zero");
        for (int c = 1; c < TIMEOUT; c++) tick();
        store(BASE + 32'd4, 32'd1);
        check("race done", 32'(done), 32'd1);
        check("race timeout", 32'(timeout), 32'd0);
        check("race cpu_reset", 32'(cpu_reset), 32'd1);

        // Reset in the middle of LOAD.
        startSession({32'h11, 32'h22, 32'h33, 32'h44}, 3'd4, 2'd0);
        tick();
        check("midload strobe", 32'(Ext_MemWrite), 32'd1);
        reset = 1'b1;
        tick();
        check("midload reset strobe", 32'(Ext_MemWrite), 32'd0);
        check("midload reset cpu_reset", 32'(cpu_reset), 32'd1);
        check("midload reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        check("midload idle strobe", 32'(Ext_MemWrite), 32'd0);
        check("midload idle busy", 32'(busy), 32'd0);

        for (int s = 0; s < 40; s++) randomSession(s);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
